// File: rtl/alu_host_driver_if.sv
// -----------------------------------------------------------------------------
// alu_host_driver_if
//   Groups the request port, response port and ALU pin bus of alu_host_driver.
//
//   Request  : req_valid/req_ready handshake, req_a/req_b (4b), req_op (3b)
//   Response : rsp_valid/rsp_ready handshake, rsp_result (8b)
//   ALU pins : alu_ui (to ui_in), alu_uio (to uio_in), alu_ena (to ena),
//              alu_uo (from uo_out)
//
//   slave  : the driver block (accepts requests, drives the ALU pins)
//   master : the environment (issues requests, consumes responses, and
//            provides the ALU's uo_out)
// -----------------------------------------------------------------------------
interface alu_host_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [2:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [7:0] alu_ui;
    logic [7:0] alu_uio;
    logic       alu_ena;
    logic [7:0] alu_uo;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_uo,
        output req_ready, rsp_valid, rsp_result, alu_ui, alu_uio, alu_ena
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_uo,
        input  req_ready, rsp_valid, rsp_result, alu_ui, alu_uio, alu_ena
    );
endinterface

// File: rtl/alu_host_driver.sv
// -----------------------------------------------------------------------------
// alu_host_driver
//   Host-side sequencer for the 8-bit ALU tile. A request (A, B, op) accepted
//   on the valid/ready request port is driven onto the ALU pins, held for
//   LATENCY+1 cycles with alu_ena high, then uo_out is captured and returned
//   on the valid/ready response port.
//
//   Parameters:
//     LATENCY   : cycles from the first drive cycle to the cycle whose closing
//                 edge samples alu_uo (0..15)
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     bus       : request/response handshakes and ALU pin bus (slave side)
//     txn_count : completed response handshakes, 8-bit wrapping
// -----------------------------------------------------------------------------
module alu_host_driver #(
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_host_driver_if.slave   bus,
    output logic [7:0]         txn_count
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     state_q,  state_d;
    logic [3:0] a_q,      a_d;
    logic [3:0] b_q,      b_d;
    logic [2:0] op_q,     op_d;
    logic [3:0] cnt_q,    cnt_d;
    logic [7:0] result_q, result_d;
    logic [7:0] txn_q,    txn_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 3'd0;
            cnt_q    <= 4'd0;
            result_q <= 8'd0;
            txn_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            txn_q    <= txn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        txn_d    = txn_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d = LAT;
                if (LATENCY == 0) begin
                    // Zero-latency ALU: its output already reflects this
                    // cycle's operands.
                    result_d = bus.alu_uo;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= rather than == so a corrupted zero count cannot trap
                // the sequencer in WAIT for 16 cycles.
                if (cnt_q <= 4'd1) begin
                    result_d = bus.alu_uo;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    txn_d   = txn_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode the state register only, so there is no
    // combinational path from req_valid or rsp_ready.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_result = result_q;

    // Operand bus keeps the last accepted operands; alu_ena qualifies them.
    assign bus.alu_ui  = {b_q, a_q};
    assign bus.alu_uio = {5'd0, op_q};
    assign bus.alu_ena = (state_q == S_DRIVE) || (state_q == S_WAIT);

    assign txn_count = txn_q;

endmodule

// File: tb/tb_alu_host_driver.sv
module tb_alu_host_driver;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic [7:0] txn_a;
    logic [7:0] txn_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_a       = 0;
    int acc_b       = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_host_driver_if ifa();
    alu_host_driver_if ifb();

    alu_host_driver #(.LATENCY(2)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .bus       (ifa),
        .txn_count (txn_a)
    );

    alu_host_driver #(.LATENCY(0)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .bus       (ifb),
        .txn_count (txn_b)
    );

    // ALU pin-level model: decodes ui_in/uio_in.
    function automatic logic [7:0] alu_f(input logic [7:0] ui, input logic [7:0] uio);
        logic [3:0] a;
        logic [3:0] b;
        a = ui[3:0];
        b = ui[7:4];
        case (uio[2:0])
            3'd0:    return {4'd0, a} + {4'd0, b};
            3'd1:    return {4'd0, a & b};
            3'd2:    return {4'd0, a ^ b};
            default: return 8'hEE;
        endcase
    endfunction

    // Expected result for a request, from its operand fields.
    function automatic logic [7:0] exp_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        if (op == 3'd0) return 8'(a) + 8'(b);
        if (op == 3'd1) return 8'(a & b);
        if (op == 3'd2) return 8'(a ^ b);
        return 8'hEE;
    endfunction

    // LATENCY=2 ALU: two pipeline registers; LATENCY=0 ALU: combinational.
    logic [7:0] pa0, pa1;
    always @(posedge clk) begin
        pa0 <= alu_f(ifa.alu_ui, ifa.alu_uio);
        pa1 <= pa0;
    end
    assign ifa.alu_uo = pa1;
    assign ifb.alu_uo = alu_f(ifb.alu_ui, ifb.alu_uio);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: push on request handshake, pop/compare on response handshake.
    always @(negedge clk) begin
        if (!rst_a && ifa.req_valid && ifa.req_ready) begin
            q_a.push_back(exp_f(ifa.req_a, ifa.req_b, ifa.req_op));
            acc_a++;
        end
        if (!rst_a && ifa.rsp_valid && ifa.rsp_ready) begin
            vectors++;
            assert (q_a.size() != 0) else begin
                miscompares++;
                $error("FAIL a_rsp_unexpected: observed=%0h expected=none", ifa.rsp_result);
            end
            if (q_a.size() != 0) begin
                $display("txn A result=%02h expected=%02h", ifa.rsp_result, q_a[0]);
                check("a_rsp_result", ifa.rsp_result, q_a.pop_front());
            end
        end
        if (!rst_b && ifb.req_valid && ifb.req_ready) begin
            q_b.push_back(exp_f(ifb.req_a, ifb.req_b, ifb.req_op));
            acc_b++;
        end
        if (!rst_b && ifb.rsp_valid && ifb.rsp_ready) begin
            vectors++;
            assert (q_b.size() != 0) else begin
                miscompares++;
                $error("FAIL b_rsp_unexpected: observed=%0h expected=none", ifb.rsp_result);
            end
            if (q_b.size() != 0) begin
                $display("txn B result=%02h expected=%02h", ifb.rsp_result, q_b[0]);
                check("b_rsp_result", ifb.rsp_result, q_b.pop_front());
            end
        end
    end

    // Present a request on A and return one cycle after it is accepted
    // (i.e. #1 into the DRIVE cycle) with req_valid dropped.
    task automatic issue_a(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        @(posedge clk); #1;
        ifa.req_valid = 1'b1;
        ifa.req_a     = a;
        ifa.req_b     = b;
        ifa.req_op    = op;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ifa.req_ready) break;
        end
        check("a_issue_ready", ifa.req_ready, 1'b1);
        @(posedge clk); #1;
        ifa.req_valid = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (q_a.size() == 0 && ifa.req_ready) break;
        end
        check(tag, q_a.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int acc0;
        int last_acc;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_a = 4'd0; ifa.req_b = 4'd0; ifa.req_op = 3'd0;
        ifa.rsp_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_a = 4'd0; ifb.req_b = 4'd0; ifb.req_op = 3'd0;
        ifb.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready",  ifa.req_ready,  1'b1);
        check("rst_rsp_valid",  ifa.rsp_valid,  1'b0);
        check("rst_rsp_result", ifa.rsp_result, 8'h00);
        check("rst_alu_ui",     ifa.alu_ui,     8'h00);
        check("rst_alu_uio",    ifa.alu_uio,    8'h00);
        check("rst_alu_ena",    ifa.alu_ena,    1'b0);
        check("rst_txn",        txn_a,          8'h00);
        check("rst_b_ready",    ifb.req_ready,  1'b1);

        // 1. Single add, LATENCY=2: 7+9 = 0x10
        issue_a(4'h7, 4'h9, 3'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_ena",       ifa.alu_ena,   1'b1);
            check("t1_alu_ui",    ifa.alu_ui,    8'h97);
            check("t1_alu_uio",   ifa.alu_uio,   8'h00);
            check("t1_rsp_valid", ifa.rsp_valid, 1'b0);
            check("t1_req_ready", ifa.req_ready, 1'b0);
        end
        @(posedge clk); #1;
        ifa.rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_rsp_valid_rise", ifa.rsp_valid,  1'b1);
        check("t1_ena_off",        ifa.alu_ena,    1'b0);
        check("t1_result",         ifa.rsp_result, 8'h10);
        @(posedge clk); #1;
        ifa.rsp_ready = 1'b0;
        @(negedge clk);
        check("t1_idle_ready", ifa.req_ready, 1'b1);
        check("t1_rsp_drop",   ifa.rsp_valid, 1'b0);
        check("t1_txn",        txn_a,         8'd1);
        check("t1_ui_held",    ifa.alu_ui,    8'h97);

        // 2. Back-pressure: C & A = 0x08, rsp_ready low for 5 cycles
        issue_a(4'hC, 4'hA, 3'd1);
        for (int k = 0; k < 20; k++) begin
            if (ifa.rsp_valid) break;
            @(negedge clk);
        end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            check("t2_rsp_valid", ifa.rsp_valid,  1'b1);
            check("t2_result",    ifa.rsp_result, 8'h08);
            check("t2_req_ready", ifa.req_ready,  1'b0);
        end
        @(posedge clk); #1;
        ifa.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifa.rsp_ready = 1'b0;
        @(negedge clk);
        check("t2_idle_ready", ifa.req_ready, 1'b1);
        check("t2_txn",        txn_a,         8'd2);

        // 3. Request while busy: 3+4 = 7, then 5^6 = 3 held during WAIT
        ifa.rsp_ready = 1'b1;
        acc0 = acc_a;
        issue_a(4'h3, 4'h4, 3'd0);
        @(posedge clk); #1;
        ifa.req_valid = 1'b1;
        ifa.req_a     = 4'h5;
        ifa.req_b     = 4'h6;
        ifa.req_op    = 3'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_busy_ready", ifa.req_ready, 1'b0);
        end
        @(negedge clk);
        check("t3_idle_ready", ifa.req_ready, 1'b1);
        @(posedge clk); #1;
        ifa.req_valid = 1'b0;
        drain_a("t3_drain");
        check("t3_accepts", acc_a - acc0, 2);
        check("t3_txn",     txn_a,        8'd4);

        // 4. LATENCY=0: F ^ 3 = 0x0C
        @(posedge clk); #1;
        ifb.req_valid = 1'b1;
        ifb.req_a     = 4'hF;
        ifb.req_b     = 4'h3;
        ifb.req_op    = 3'd2;
        @(negedge clk);
        check("t4_ready",    ifb.req_ready, 1'b1);
        check("t4_ena_pre",  ifb.alu_ena,   1'b0);
        @(posedge clk); #1;
        ifb.req_valid = 1'b0;
        @(negedge clk);
        check("t4_ena",      ifb.alu_ena,   1'b1);
        check("t4_alu_ui",   ifb.alu_ui,    8'h3F);
        check("t4_alu_uio",  ifb.alu_uio,   8'h02);
        check("t4_rsp_pre",  ifb.rsp_valid, 1'b0);
        @(posedge clk); #1;
        ifb.rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_ena_off",  ifb.alu_ena,    1'b0);
        check("t4_rsp",      ifb.rsp_valid,  1'b1);
        check("t4_result",   ifb.rsp_result, 8'h0C);
        @(posedge clk); #1;
        ifb.rsp_ready = 1'b0;
        @(negedge clk);
        check("t4_idle",     ifb.req_ready, 1'b1);
        check("t4_txn",      txn_b,         8'd1);
        check("t4_q_empty",  q_b.size(),    0);

        // 5. Reset in WAIT
        issue_a(4'h1, 4'h2, 3'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        q_a.delete();
        @(negedge clk);
        check("t5_rsp_valid", ifa.rsp_valid,  1'b0);
        check("t5_ena",       ifa.alu_ena,    1'b0);
        check("t5_alu_ui",    ifa.alu_ui,     8'h00);
        check("t5_txn",       txn_a,          8'h00);
        check("t5_req_ready", ifa.req_ready,  1'b1);
        check("t5_result",    ifa.rsp_result, 8'h00);

        // 6. Counter wrap: 256 back-to-back transactions, rsp_ready tied high
        ifa.rsp_ready = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            ifa.req_valid = 1'b1;
            ifa.req_a     = 4'(i);
            ifa.req_b     = 4'(i >> 4);
            ifa.req_op    = 3'(i % 3);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (ifa.req_ready) break;
            end
            check("t6_accept", ifa.req_ready, 1'b1);
            if (i > 0) check("t6_period", cyc - last_acc, 5);
            last_acc = cyc;
            if (i == 255) check("t6_txn_ff", txn_a, 8'hFF);
        end
        @(posedge clk); #1;
        ifa.req_valid = 1'b0;
        drain_a("t6_drain");
        check("t6_txn_wrap", txn_a, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
